// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl_pkg
// Description : Shared state encoding and phase constants for the
//               clock-phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

    localparam int NUM_PHASES = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE  = 2'd0;
    localparam state_t c_RUN   = 2'd1;
    localparam state_t c_STALL = 2'd2;

    localparam logic [NUM_PHASES-1:0] PH0 = 4'b0001;
    localparam logic [NUM_PHASES-1:0] PH1 = 4'b0010;
    localparam logic [NUM_PHASES-1:0] PH2 = 4'b0100;
    localparam logic [NUM_PHASES-1:0] PH3 = 4'b1000;

    function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [1:0] idx);
        logic [NUM_PHASES-1:0] v;
        case (idx)
            2'd0:    v = PH0;
            2'd1:    v = PH1;
            2'd2:    v = PH2;
            default: v = PH3;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_tick_gen
// Description : Divide counter; tick marks the last clock of each phase.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_tick_gen
    import clock_ctrl_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] ratio,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] w_last;

    // ratio is never zero, so ratio-1 cannot underflow
    assign w_last = ratio - {{(DIV_W-1){1'b0}}, 1'b1};
    assign tick   = enable && (r_count == w_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_ctrl
// Description : Programmable four-phase clock sequencer with stall and
//               divide-ratio reconfiguration handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_phase_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  stall_req,
    output logic                  stall_ack,
    input  logic                  cfg_valid,
    input  logic [DIV_W-1:0]      cfg_div,
    output logic                  cfg_ready,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [1:0]            phase_idx,
    output logic                  clock_out,
    output logic                  busy
);

    localparam logic [DIV_W-1:0] c_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] c_ONE         = DIV_W'(1);

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;
    logic [1:0]            r_phase_idx;
    logic [NUM_PHASES-1:0] r_phase_en;
    logic                  r_clock_out;
    logic                  r_stall_ack;

    state_t                w_state_nxt;
    logic [1:0]            w_idx_nxt;
    logic [NUM_PHASES-1:0] w_pe_nxt;
    logic                  w_co_nxt;
    logic                  w_sa_nxt;
    logic [1:0]            w_idx_plus;
    logic                  w_tick;
    logic                  w_running;
    logic                  w_boundary;
    logic [DIV_W-1:0]      w_cfg_div;

    assign w_running  = (r_state == c_RUN);
    assign w_boundary = w_running && (r_phase_idx == 2'd3) && w_tick;
    assign w_idx_plus = r_phase_idx + 2'd1;
    assign w_cfg_div  = (cfg_div == '0) ? c_ONE : cfg_div;

    clock_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk    (clock_in),
        .rst    (reset),
        .enable (w_running),
        .clear  (!w_running),
        .ratio  (r_div),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_phase_idx;
        w_pe_nxt    = '0;
        w_co_nxt    = r_clock_out;
        w_sa_nxt    = r_stall_ack;
        case (r_state)
            c_IDLE: begin
                w_idx_nxt = 2'd0;
                w_co_nxt  = 1'b0;
                w_sa_nxt  = 1'b0;
                if (run) begin
                    w_state_nxt = c_RUN;
                    w_pe_nxt    = PH0;
                    w_co_nxt    = 1'b1;
                end
            end
            c_RUN: begin
                if (w_tick) begin
                    // run/stall_req only matter at the frame boundary
                    if (r_phase_idx == 2'd3) begin
                        if (!run) begin
                            w_state_nxt = c_IDLE;
                            w_idx_nxt   = 2'd0;
                            w_co_nxt    = 1'b0;
                        end else if (stall_req) begin
                            w_state_nxt = c_STALL;
                            w_sa_nxt    = 1'b1;
                            w_co_nxt    = 1'b0;
                        end else begin
                            w_idx_nxt = 2'd0;
                            w_pe_nxt  = PH0;
                            w_co_nxt  = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = w_idx_plus;
                        w_pe_nxt  = phase_onehot(w_idx_plus);
                        w_co_nxt  = (r_phase_idx == 2'd0);
                    end
                end
            end
            c_STALL: begin
                if (!run) begin
                    w_state_nxt = c_IDLE;
                    w_idx_nxt   = 2'd0;
                    w_sa_nxt    = 1'b0;
                end else if (!stall_req) begin
                    w_state_nxt = c_RUN;
                    w_idx_nxt   = 2'd0;
                    w_pe_nxt    = PH0;
                    w_co_nxt    = 1'b1;
                    w_sa_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_idx_nxt   = 2'd0;
                w_co_nxt    = 1'b0;
                w_sa_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_div       <= c_DEFAULT_DIV;
            r_phase_idx <= 2'd0;
            r_phase_en  <= '0;
            r_clock_out <= 1'b0;
            r_stall_ack <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_idx <= w_idx_nxt;
            r_phase_en  <= w_pe_nxt;
            r_clock_out <= w_co_nxt;
            r_stall_ack <= w_sa_nxt;
            if (cfg_valid && cfg_ready) begin
                r_div <= w_cfg_div;
            end
        end
    end

    assign cfg_ready = (r_state == c_IDLE) || (r_state == c_STALL) || w_boundary;
    assign busy      = (r_state == c_RUN) || (r_state == c_STALL);
    assign phase_en  = r_phase_en;
    assign phase_idx = r_phase_idx;
    assign clock_out = r_clock_out;
    assign stall_ack = r_stall_ack;

endmodule
`default_nettype wire

// File: tb/tb_clock_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_phase_ctrl
// Description : Vector-table bench for clock_phase_ctrl with expected-value
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_phase_ctrl;

    logic       clock_in = 1'b0;
    logic       reset, run, stall_req, cfg_valid;
    logic [3:0] cfg_div;
    logic       stall_ack, cfg_ready, clock_out, busy;
    logic [3:0] phase_en;
    logic [1:0] phase_idx;

    typedef struct {
        logic       rst, run, stall, cv;
        logic [3:0] cd;
        logic [3:0] pe;
        logic [1:0] pi;
        logic       co, sa, bz, rdy;
    } vec_t;

    typedef struct {
        int         row;
        logic [3:0] pe;
        logic [1:0] pi;
        logic       co, sa, bz, rdy;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    clock_phase_ctrl #(
        .DIV_W       (4),
        .DEFAULT_DIV (2)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .run       (run),
        .stall_req (stall_req),
        .stall_ack (stall_ack),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .phase_en  (phase_en),
        .phase_idx (phase_idx),
        .clock_out (clock_out),
        .busy      (busy)
    );

    always #5 clock_in = ~clock_in;

    function automatic void add(logic rst, logic r, logic st, logic cv, logic [3:0] cd,
                                logic [3:0] pe, logic [1:0] pi, logic co, logic sa,
                                logic bz, logic rdy);
        vec_t v;
        v.rst = rst; v.run = r; v.stall = st; v.cv = cv; v.cd = cd;
        v.pe = pe; v.pi = pi; v.co = co; v.sa = sa; v.bz = bz; v.rdy = rdy;
        tbl.push_back(v);
    endfunction

    // n running cycles from the start of a frame: pulse on the first cycle of
    // each phase, clock_out high in phases 0-1, ready on the frame's last cycle
    function automatic void add_run(int div, int n);
        for (int i = 0; i < n; i++) begin
            int ph;
            int cnt;
            ph  = (i / div) % 4;
            cnt = i % div;
            add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,
                (cnt == 0) ? 4'(1 << ph) : 4'b0000, 2'(ph), (ph < 2), 1'b0, 1'b1,
                (ph == 3) && (cnt == div - 1));
        end
    endfunction

    function automatic void chk(string name, int row, logic [3:0] act, logic [3:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s row=%0d got=%b want=%b", name, row, act, want);
        end
    endfunction

    always @(negedge clock_in) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("phase_en",  e.row, phase_en,             e.pe);
            chk("phase_idx", e.row, {2'b00, phase_idx},   {2'b00, e.pi});
            chk("clock_out", e.row, {3'b000, clock_out},  {3'b000, e.co});
            chk("stall_ack", e.row, {3'b000, stall_ack},  {3'b000, e.sa});
            chk("busy",      e.row, {3'b000, busy},       {3'b000, e.bz});
            chk("cfg_ready", e.row, {3'b000, cfg_ready},  {3'b000, e.rdy});
        end
    end

    initial begin
        exp_t x;
        reset = 1'b1; run = 1'b0; stall_req = 1'b0; cfg_valid = 1'b0; cfg_div = 4'd0;

        // reset state, then run at default ratio 2
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_run(2, 16);                                        // rows 1..16
        for (int k = 11; k <= 16; k++) begin
            tbl[k].cv = 1'b1;
            tbl[k].cd = 4'd3;
        end
        add_run(3, 12);                                        // rows 17..28
        add_run(3, 12);                                        // rows 29..40
        for (int k = 32; k <= 40; k++) tbl[k].stall = 1'b1;
        for (int k = 0; k < 3; k++)                            // rows 41..43
            add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        add_run(3, 12);                                        // rows 45..56
        for (int k = 51; k <= 56; k++) tbl[k].run = 1'b0;
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_run(1, 8);                                         // rows 60..67
        for (int k = 64; k <= 67; k++) tbl[k].run = 1'b0;
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_run(5, 32);                                        // rows 70..101
        tbl[101].rst = 1'b1;                                   // mid phase 2
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_run(2, 9);                                         // rows 103..111

        repeat (2) @(posedge clock_in);
        for (int r = 0; r < tbl.size(); r++) begin
            #1;
            reset     = tbl[r].rst;
            run       = tbl[r].run;
            stall_req = tbl[r].stall;
            cfg_valid = tbl[r].cv;
            cfg_div   = tbl[r].cd;
            x.row = r; x.pe = tbl[r].pe; x.pi = tbl[r].pi; x.co = tbl[r].co;
            x.sa = tbl[r].sa; x.bz = tbl[r].bz; x.rdy = tbl[r].rdy;
            exp_q.push_back(x);
            @(posedge clock_in);
        end
        @(negedge clock_in);
        #1;
        chk("scoreboard_drained", 0, 4'(exp_q.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
